hme_ip_rgmii_tx_arb: RTL and testbench

Two-port GMII transmit frame scheduler in the `clk_eth` domain. It arbitrates round-robin between two byte-stream frame sources, inserts preamble and SFD, and enforces the inter-frame gap. It drives the `gmii_tx_en`, `gmii_txd` and `gmii_tx_er` inputs of `hme_ip_rgmii_tx`. Sources supply complete frames including FCS; the block does not generate CRC or padding.

---
 rtl/hme_ip_rgmii_tx_arb.sv | 133 +++++++++++++
 tb/tb_hme_ip_rgmii_tx_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hme_ip_rgmii_tx_arb.sv
// Two-port GMII transmit scheduler: round-robin frame grant, preamble/SFD
// insertion, underflow abort with drain, and inter-frame gap enforcement.
module hme_ip_rgmii_tx_arb #(
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_CYCLES   = 12
) (
   input  logic       clk_eth,
   input  logic       rstn,
   input  logic       i_enable,
   input  logic       s0_valid,
   input  logic [7:0] s0_data,
   input  logic       s0_last,
   output logic       s0_ready,
   input  logic       s1_valid,
   input  logic [7:0] s1_data,
   input  logic       s1_last,
   output logic       s1_ready,
   output logic       gmii_tx_en,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_er,
   output logic       o_busy,
   output logic       o_grant,
   output logic       o_underflow
);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DRAIN, IFG} state_t;

   // The IDLE cycle before a grant is part of the gap, so IFG itself lasts IFG_CYCLES-1.
   localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 2);

   state_t     state, state_next;
   logic [7:0] cnt, cnt_next;
   logic       grant_next;
   logic       tx_en_next, tx_er_next, underflow_next;
   logic [7:0] txd_next;
   logic       sel_valid, sel_last, xfer;
   logic [7:0] sel_data;

   assign sel_valid = o_grant ? s1_valid : s0_valid;
   assign sel_data  = o_grant ? s1_data  : s0_data;
   assign sel_last  = o_grant ? s1_last  : s0_last;
   assign xfer      = (state == DATA) || (state == DRAIN);
   assign s0_ready  = xfer & ~o_grant;
   assign s1_ready  = xfer & o_grant;

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      grant_next     = o_grant;
      tx_en_next     = 1'b0;
      txd_next       = 8'h00;
      tx_er_next     = 1'b0;
      underflow_next = 1'b0;
      case (state)
         IDLE: begin
            if (i_enable && (s0_valid || s1_valid)) begin
               state_next = PRE;
               cnt_next   = 8'd0;
               grant_next = (s0_valid && s1_valid) ? ~o_grant : s1_valid;
            end
         end
         PRE: begin
            tx_en_next = 1'b1;
            txd_next   = 8'h55;
            if (cnt == PRE_LAST) begin
               state_next = SFD;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         SFD: begin
            tx_en_next = 1'b1;
            txd_next   = 8'hD5;
            state_next = DATA;
         end
         DATA: begin
            tx_en_next = 1'b1;
            if (sel_valid) begin
               txd_next = sel_data;
               if (sel_last) begin
                  state_next = IFG;
                  cnt_next   = 8'd0;
               end
            end else begin
               tx_er_next     = 1'b1;
               underflow_next = 1'b1;
               state_next     = DRAIN;
            end
         end
         DRAIN: begin
            if (sel_valid && sel_last) begin
               state_next = IFG;
               cnt_next   = 8'd0;
            end
         end
         IFG: begin
            if (cnt == IFG_LAST) begin
               state_next = IDLE;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // o_grant resets to 1 so that port 0 wins the first contention.
   always_ff @(posedge clk_eth or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         o_grant     <= 1'b1;
         gmii_tx_en  <= 1'b0;
         gmii_txd    <= 8'h00;
         gmii_tx_er  <= 1'b0;
         o_underflow <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         o_grant     <= grant_next;
         gmii_tx_en  <= tx_en_next;
         gmii_txd    <= txd_next;
         gmii_tx_er  <= tx_er_next;
         o_underflow <= underflow_next;
         o_busy      <= (state != IDLE);
      end
   end

endmodule

// File: tb/tb_hme_ip_rgmii_tx_arb.sv
// Directed bench for hme_ip_rgmii_tx_arb: records GMII outputs every cycle
// and compares frame shape, gap, arbitration order and abort behaviour.
module tb_hme_ip_rgmii_tx_arb;

   logic       clk_eth = 1'b0;
   logic       rstn = 1'b0;
   logic       i_enable = 1'b1;
   logic       s0_valid = 1'b0, s1_valid = 1'b0;
   logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
   logic       s0_last = 1'b0, s1_last = 1'b0;
   logic       s0_ready, s1_ready;
   logic       gmii_tx_en, gmii_tx_er, o_busy, o_grant, o_underflow;
   logic [7:0] gmii_txd;

   int checks = 0;
   int errors = 0;
   logic abort = 1'b0;

   typedef struct packed {
      logic       en;
      logic [7:0] txd;
      logic       er;
      logic       uf;
      logic       busy;
   } sample_t;

   sample_t trace[$];

   hme_ip_rgmii_tx_arb #(.PREAMBLE_LEN(7), .IFG_CYCLES(12)) dut (
      .clk_eth(clk_eth), .rstn(rstn), .i_enable(i_enable),
      .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
      .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .gmii_tx_er(gmii_tx_er),
      .o_busy(o_busy), .o_grant(o_grant), .o_underflow(o_underflow)
   );

   always #4 clk_eth = ~clk_eth;

   always @(negedge clk_eth)
      trace.push_back({gmii_tx_en, gmii_txd, gmii_tx_er, o_underflow, o_busy});

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic sample_t at(input int i);
      if (i >= 0 && i < trace.size()) return trace[i];
      return '{en: 1'b0, txd: 8'hEE, er: 1'b0, uf: 1'b0, busy: 1'b1};
   endfunction

   function automatic int firstEn(input int from);
      for (int i = from; i < trace.size(); i++)
         if (trace[i].en) return i;
      return -1;
   endfunction

   function automatic int runLen(input int s);
      int n = 0;
      if (s < 0) return 0;
      while (s + n < trace.size() && trace[s + n].en) n++;
      return n;
   endfunction

   // which: 0 = en, 1 = er, 2 = underflow
   function automatic int countField(input int from, input int which);
      int n = 0;
      for (int i = from; i < trace.size(); i++)
         n += int'(which == 0 ? trace[i].en : which == 1 ? trace[i].er : trace[i].uf);
      return n;
   endfunction

   function automatic logic rdy(input int port);
      return (port == 1) ? s1_ready : s0_ready;
   endfunction

   task automatic setSrc(input int port, input logic v, input logic [7:0] d, input logic l);
      if (port == 1) begin
         s1_valid = v; s1_data = d; s1_last = l;
      end else begin
         s0_valid = v; s0_data = d; s0_last = l;
      end
   endtask

   // Drives one frame on a port; dropAt inserts a single valid-low cycle before that byte.
   task automatic applyStimulus(input int port, input int len, input logic [7:0] base,
                                input logic [7:0] step, input int dropAt);
      int n;
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         if (i == dropAt) begin
            @(negedge clk_eth);
            setSrc(port, 1'b0, 8'h00, 1'b0);
         end
         d = base + step * 8'(i);
         @(negedge clk_eth);
         setSrc(port, 1'b1, d, i == len - 1);
         n = 0;
         while (!rdy(port) && !abort && n < 2000) begin
            @(negedge clk_eth);
            n++;
         end
         if (abort) break;
         if (n >= 2000) begin
            checkOutput("ready_timeout", n, 0);
            break;
         end
         @(posedge clk_eth);
      end
      @(negedge clk_eth);
      setSrc(port, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic applyReset();
      rstn = 1'b0;
      i_enable = 1'b1;
      setSrc(0, 1'b0, 8'h00, 1'b0);
      setSrc(1, 1'b0, 8'h00, 1'b0);
      repeat (2) @(negedge clk_eth);
      rstn = 1'b1;
      @(negedge clk_eth);
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((o_busy || gmii_tx_en) && n < 1000) begin
         @(negedge clk_eth);
         n++;
      end
      checkOutput("idle_reached", n < 1000, 1);
      repeat (2) @(negedge clk_eth);
      #1;
   endtask

   // Two frames back to back: first byte of each identifies the port, gap must be 12.
   task automatic checkPair(input int mark, input logic [7:0] firstByte, input logic [7:0] secondByte);
      int s1, s2, e1;
      s1 = firstEn(mark);
      e1 = s1 + runLen(s1);
      s2 = firstEn(e1);
      checkOutput("pair_len_a", runLen(s1), 10);
      checkOutput("pair_byte_a", at(s1 + 8).txd, firstByte);
      checkOutput("pair_gap", s2 - e1, 12);
      checkOutput("pair_len_b", runLen(s2), 10);
      checkOutput("pair_byte_b", at(s2 + 8).txd, secondByte);
   endtask

   initial begin
      int mark, s, len, f, b, bad, n, s1Seen;

      applyReset();
      checkOutput("rst_tx_en", gmii_tx_en, 0);
      checkOutput("rst_txd", gmii_txd, 8'h00);
      checkOutput("rst_tx_er", gmii_tx_er, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_grant", o_grant, 1);
      checkOutput("rst_underflow", o_underflow, 0);
      checkOutput("rst_ready", {s0_ready, s1_ready}, 0);

      // Single 4-byte frame on port 0.
      mark = trace.size();
      applyStimulus(0, 4, 8'h11, 8'h11, -1);
      waitIdle();
      s = firstEn(mark);
      len = runLen(s);
      checkOutput("t1_len", len, 12);
      bad = 0;
      for (int i = 0; i < 7; i++) bad += int'(at(s + i).txd != 8'h55);
      checkOutput("t1_preamble_bad", bad, 0);
      checkOutput("t1_sfd", at(s + 7).txd, 8'hD5);
      for (int i = 0; i < 4; i++) checkOutput("t1_data", at(s + 8 + i).txd, 8'h11 * 8'(i + 1));
      checkOutput("t1_er_count", countField(mark, 1), 0);
      checkOutput("t1_grant", o_grant, 0);
      f = s + len;
      b = f;
      while (b < trace.size() && trace[b].busy) b++;
      checkOutput("t1_busy_fall", b - f, 11);

      // Contention after reset: port 0 then port 1, twice.
      applyReset();
      for (int r = 0; r < 2; r++) begin
         mark = trace.size();
         fork
            applyStimulus(0, 2, 8'hA0, 8'h01, -1);
            applyStimulus(1, 2, 8'hB0, 8'h01, -1);
         join
         waitIdle();
         checkPair(mark, 8'hA0, 8'hB0);
      end

      // Port 1 underflow after 2 of 5 bytes.
      applyReset();
      mark = trace.size();
      applyStimulus(1, 5, 8'h60, 8'h01, 2);
      waitIdle();
      s = firstEn(mark);
      len = runLen(s);
      checkOutput("t3_len", len, 11);
      checkOutput("t3_byte1", at(s + 9).txd, 8'h61);
      checkOutput("t3_abort", {at(s + 10).er, at(s + 10).txd, at(s + 10).uf}, {1'b1, 8'h00, 1'b1});
      checkOutput("t3_en_total", countField(mark, 0), 11);
      checkOutput("t3_er_total", countField(mark, 1), 1);
      checkOutput("t3_uf_total", countField(mark, 2), 1);

      // Enable held low for 50 cycles, then raised.
      applyReset();
      i_enable = 1'b0;
      fork
         applyStimulus(0, 2, 8'h30, 8'h01, -1);
         begin
            bad = 0;
            repeat (50) begin
               @(negedge clk_eth);
               bad += int'(gmii_tx_en || s0_ready || o_busy);
            end
            checkOutput("t4_held_off", bad, 0);
            i_enable = 1'b1;
            @(negedge clk_eth);
            checkOutput("t4_grant_edge", gmii_tx_en, 0);
            @(negedge clk_eth);
            checkOutput("t4_preamble", {gmii_tx_en, gmii_txd}, {1'b1, 8'h55});
         end
      join
      waitIdle();
      checkOutput("t4_grant", o_grant, 0);

      // Enable dropped mid-frame: 64 bytes complete, pending port 1 never granted.
      applyReset();
      mark = trace.size();
      s1Seen = 0;
      fork
         applyStimulus(0, 64, 8'h00, 8'h01, -1);
         begin
            n = 0;
            while (!s0_ready && n < 100) begin
               @(negedge clk_eth);
               n++;
            end
            repeat (5) @(negedge clk_eth);
            i_enable = 1'b0;
            setSrc(1, 1'b1, 8'hC0, 1'b1);
            repeat (200) begin
               @(negedge clk_eth);
               s1Seen += int'(s1_ready);
            end
         end
      join
      s = firstEn(mark);
      checkOutput("t5_len", runLen(s), 72);
      bad = 0;
      for (int i = 0; i < 64; i++) bad += int'(at(s + 8 + i).txd != 8'(i));
      checkOutput("t5_data_bad", bad, 0);
      checkOutput("t5_s1_ready", s1Seen, 0);
      checkOutput("t5_en_total", countField(mark, 0), 72);
      checkOutput("t5_idle", {o_busy, gmii_tx_en}, 0);
      setSrc(1, 1'b0, 8'h00, 1'b0);
      i_enable = 1'b1;

      // Reset pulsed during the preamble, then a clean frame.
      applyReset();
      fork
         applyStimulus(0, 3, 8'h50, 8'h01, -1);
         begin
            n = 0;
            while (!gmii_tx_en && n < 100) begin
               @(negedge clk_eth);
               n++;
            end
            repeat (2) @(negedge clk_eth);
            rstn = 1'b0;
            #1;
            checkOutput("t6_rst_out", {gmii_tx_en, gmii_tx_er, o_busy, gmii_txd}, 0);
            abort = 1'b1;
         end
      join
      @(negedge clk_eth);
      abort = 1'b0;
      rstn = 1'b1;
      mark = trace.size();
      applyStimulus(0, 3, 8'h70, 8'h01, -1);
      waitIdle();
      s = firstEn(mark);
      checkOutput("t6_len", runLen(s), 11);
      checkOutput("t6_first", at(s + 8).txd, 8'h70);
      checkOutput("t6_last", at(s + 10).txd, 8'h72);
      checkOutput("t6_grant", o_grant, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
